// File: rtl/cfg_pkg.sv
// ----------------------------------------------------------------------------
// cfg_pkg
// Shared definitions for the timer preset configuration controller.
//   - cfg_state_e : controller FSM states
//   - SLOT_*      : preset slot indices
//   - DEF_*       : power-on preset values in seconds
//   - MAX_VAL / MIN_VAL : clamp limits applied while editing
// Used by preset_cfg_ctrl and sat_step_adder.
// ----------------------------------------------------------------------------
package cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        EDIT   = 2'd2,
        COMMIT = 2'd3
    } cfg_state_e;

    localparam int SLOT_WORK    = 0;
    localparam int SLOT_CLEAN   = 1;
    localparam int SLOT_GESTURE = 2;
    localparam int SLOT_COUNT   = 3;

    localparam int DEF_WORK    = 3600;
    localparam int DEF_CLEAN   = 180;
    localparam int DEF_GESTURE = 60;
    localparam int DEF_COUNT   = 5;

    localparam int MAX_VAL = 5999;
    localparam int MIN_VAL = 1;

endpackage

// File: rtl/sat_step_adder.sv
// ----------------------------------------------------------------------------
// sat_step_adder
// Purely combinational saturating add/subtract used by the edit shadow.
// Ports:
//   value  in  W    current shadow value
//   step   in  4    magnitude in seconds (0 behaves as 1)
//   dir    in  1    1 = increment, 0 = decrement
//   result out W+1  value +/- step clamped to [MIN_VAL, MAX_VAL]
// ----------------------------------------------------------------------------
module sat_step_adder
    import cfg_pkg::*;
#(
    parameter int W       = 16,
    parameter int MAX_LIM = MAX_VAL,
    parameter int MIN_LIM = MIN_VAL
) (
    input  logic [W-1:0] value,
    input  logic [3:0]   step,
    input  logic         dir,
    output logic [W:0]   result
);

    logic [W:0] value_ext;
    logic [W:0] step_ext;
    logic [W:0] sum;
    logic [W:0] max_ext;
    logic [W:0] min_ext;

    // One extra bit of headroom means the sum can never wrap; the
    // decrement side compares before subtracting so it cannot underflow.
    always_comb begin
        value_ext = {1'b0, value};
        step_ext  = (step == 4'd0) ? (W+1)'(1) : (W+1)'(step);
        max_ext   = (W+1)'(MAX_LIM);
        min_ext   = (W+1)'(MIN_LIM);
        sum       = value_ext + step_ext;
        if (dir) begin
            result = (sum > max_ext) ? max_ext : sum;
        end else begin
            result = (value_ext < step_ext + min_ext) ? min_ext
                                                      : value_ext - step_ext;
        end
    end

endmodule

// File: rtl/preset_cfg_ctrl.sv
// ----------------------------------------------------------------------------
// preset_cfg_ctrl
// Owns the four timer presets (work limit, self-clean, gesture window,
// countdown) and runs the select / edit / commit sequence from single-cycle
// button pulses. Committed presets only change on a COMMIT cycle (or a
// restore), so timers never observe a half-edited value.
//
// Optional feature macro: PRESET_RESTORE_EN
//   When defined, adds input restore_def which reloads all defaults from
//   IDLE or SELECT.
//
// Ports:
//   clk               in   system clock
//   reset             in   asynchronous active-low reset
//   set_req           in   enter configuration mode (IDLE only)
//   sel_next          in   advance selected slot 0->1->2->3->0
//   step[3:0]         in   inc/dec magnitude in seconds, 0 treated as 1
//   inc / dec         in   adjust the edit shadow
//   confirm / cancel  in   descend/commit or back out
//   restore_def       in   (PRESET_RESTORE_EN only) reload defaults
//   preset0..preset3  out  committed presets
//   edit_val          out  shadow value under edit
//   sel               out  selected slot
//   cfg_busy          out  high whenever not IDLE
//   cfg_done          out  one-cycle pulse after a commit or restore
// ----------------------------------------------------------------------------
module preset_cfg_ctrl
    import cfg_pkg::*;
#(
    parameter int W       = 16,
    parameter int DEF0    = DEF_WORK,
    parameter int DEF1    = DEF_CLEAN,
    parameter int DEF2    = DEF_GESTURE,
    parameter int DEF3    = DEF_COUNT,
    parameter int MAX_VAL = cfg_pkg::MAX_VAL,
    parameter int MIN_VAL = cfg_pkg::MIN_VAL
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         set_req,
    input  logic         sel_next,
    input  logic [3:0]   step,
    input  logic         inc,
    input  logic         dec,
    input  logic         confirm,
    input  logic         cancel,
`ifdef PRESET_RESTORE_EN
    input  logic         restore_def,
`endif
    output logic [W-1:0] preset0,
    output logic [W-1:0] preset1,
    output logic [W-1:0] preset2,
    output logic [W-1:0] preset3,
    output logic [W-1:0] edit_val,
    output logic [1:0]   sel,
    output logic         cfg_busy,
    output logic         cfg_done
);

    cfg_state_e   state;
    cfg_state_e   state_next;
    logic [W-1:0] presets [4];
    logic [W:0]   step_result;
    logic         restore_req;
    logic         do_sel_rst;
    logic         do_sel_adv;
    logic         do_load;
    logic         do_step;
    logic         do_commit;
    logic         do_restore;

`ifdef PRESET_RESTORE_EN
    assign restore_req = restore_def;
`else
    assign restore_req = 1'b0;
`endif

    // inc is only consulted when it is the acting pulse, so it doubles as
    // the direction select (dec acts only when inc is low).
    sat_step_adder #(
        .W       (W),
        .MAX_LIM (MAX_VAL),
        .MIN_LIM (MIN_VAL)
    ) u_adder (
        .value  (edit_val),
        .step   (step),
        .dir    (inc),
        .result (step_result)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and action decode. Priority within a cycle is
    // cancel > restore > confirm > inc > dec > sel_next; only one acts.
    always_comb begin
        state_next = state;
        do_sel_rst = 1'b0;
        do_sel_adv = 1'b0;
        do_load    = 1'b0;
        do_step    = 1'b0;
        do_commit  = 1'b0;
        do_restore = 1'b0;
        case (state)
            IDLE: begin
                if (restore_req) begin
                    do_restore = 1'b1;
                end else if (set_req) begin
                    state_next = SELECT;
                    do_sel_rst = 1'b1;
                end
            end
            SELECT: begin
                if (cancel) begin
                    state_next = IDLE;
                end else if (restore_req) begin
                    do_restore = 1'b1;
                end else if (confirm) begin
                    state_next = EDIT;
                    do_load    = 1'b1;
                end else if (sel_next) begin
                    do_sel_adv = 1'b1;
                end
            end
            EDIT: begin
                if (cancel) begin
                    state_next = SELECT;
                end else if (confirm) begin
                    state_next = COMMIT;
                end else if (inc || dec) begin
                    do_step = 1'b1;
                end
            end
            COMMIT: begin
                state_next = SELECT;
                do_commit  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presets[SLOT_WORK]    <= W'(DEF0);
            presets[SLOT_CLEAN]   <= W'(DEF1);
            presets[SLOT_GESTURE] <= W'(DEF2);
            presets[SLOT_COUNT]   <= W'(DEF3);
            edit_val <= '0;
            sel      <= 2'd0;
            cfg_busy <= 1'b0;
            cfg_done <= 1'b0;
        end else begin
            cfg_busy <= (state_next != IDLE);
            cfg_done <= do_commit | do_restore;
            if (do_restore) begin
                presets[SLOT_WORK]    <= W'(DEF0);
                presets[SLOT_CLEAN]   <= W'(DEF1);
                presets[SLOT_GESTURE] <= W'(DEF2);
                presets[SLOT_COUNT]   <= W'(DEF3);
            end else if (do_commit) begin
                presets[sel] <= edit_val;
            end
            if (do_sel_rst) begin
                sel <= 2'd0;
            end else if (do_sel_adv) begin
                sel <= sel + 2'd1;
            end
            if (do_load) begin
                edit_val <= presets[sel];
            end else if (do_step) begin
                // The adder already clamps; the top bit is a defensive guard.
                edit_val <= step_result[W] ? W'(MAX_VAL) : step_result[W-1:0];
            end
        end
    end

    // Output mapping from registered storage
    assign preset0 = presets[SLOT_WORK];
    assign preset1 = presets[SLOT_CLEAN];
    assign preset2 = presets[SLOT_GESTURE];
    assign preset3 = presets[SLOT_COUNT];

endmodule

// File: tb/tb_preset_cfg_ctrl.sv
// ----------------------------------------------------------------------------
// tb_preset_cfg_ctrl
// Directed self-checking bench for preset_cfg_ctrl. Inputs change on the
// falling edge and outputs are sampled on the falling edge.
// Optional feature macro: PRESET_RESTORE_EN (adds the restore scenario).
// ----------------------------------------------------------------------------
module tb_preset_cfg_ctrl;

    logic        clk;
    logic        reset;
    logic        set_req;
    logic        sel_next;
    logic [3:0]  step;
    logic        inc;
    logic        dec;
    logic        confirm;
    logic        cancel;
    logic        restore_def;
    logic [15:0] preset0;
    logic [15:0] preset1;
    logic [15:0] preset2;
    logic [15:0] preset3;
    logic [15:0] edit_val;
    logic [1:0]  sel;
    logic        cfg_busy;
    logic        cfg_done;

    int errors;
    int checks;

    preset_cfg_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .set_req     (set_req),
        .sel_next    (sel_next),
        .step        (step),
        .inc         (inc),
        .dec         (dec),
        .confirm     (confirm),
        .cancel      (cancel),
`ifdef PRESET_RESTORE_EN
        .restore_def (restore_def),
`endif
        .preset0     (preset0),
        .preset1     (preset1),
        .preset2     (preset2),
        .preset3     (preset3),
        .edit_val    (edit_val),
        .sel         (sel),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold the requested pulses for exactly one rising edge, starting and
    // ending on a falling edge.
    task automatic applyStimulus(input logic s_req, input logic s_next,
                                 input logic s_inc, input logic s_dec,
                                 input logic s_conf, input logic s_canc,
                                 input logic s_rest);
        set_req     = s_req;
        sel_next    = s_next;
        inc         = s_inc;
        dec         = s_dec;
        confirm     = s_conf;
        cancel      = s_canc;
        restore_def = s_rest;
        @(negedge clk);
        set_req     = 1'b0;
        sel_next    = 1'b0;
        inc         = 1'b0;
        dec         = 1'b0;
        confirm     = 1'b0;
        cancel      = 1'b0;
        restore_def = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({preset0, preset1, preset2, preset3} !== {16'd3600, 16'd180, 16'd60, 16'd5}) begin
            errors++;
            $display("[TB] FAIL reset_presets: got %0d/%0d/%0d/%0d expected 3600/180/60/5",
                     preset0, preset1, preset2, preset3);
        end
        checks++;
        if ({edit_val, sel, cfg_busy, cfg_done} !== {16'd0, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got edit=%0d sel=%0d busy=%0b done=%0b expected 0/0/0/0",
                     edit_val, sel, cfg_busy, cfg_done);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({preset0, preset1, preset2, preset3, cfg_busy} !== {16'd3600, 16'd180, 16'd60, 16'd5, 1'b0}) begin
            errors++;
            $display("[TB] FAIL post_reset: got %0d/%0d/%0d/%0d busy=%0b expected 3600/180/60/5 busy=0",
                     preset0, preset1, preset2, preset3, cfg_busy);
        end
        // set_req then cancel returns to IDLE
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (cfg_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL enter_select: got busy=%0b expected 1", cfg_busy);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (cfg_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL select_cancel: got busy=%0b expected 0", cfg_busy);
        end
        // IDLE ignores inc and sel_next
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checks++;
        if ({sel, edit_val, cfg_busy} !== {2'd0, 16'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL idle_ignore: got sel=%0d edit=%0d busy=%0b expected 0/0/0",
                     sel, edit_val, cfg_busy);
        end
    endtask

    task automatic test_commit();
        step = 4'd5;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (sel !== 2'd2) begin
            errors++;
            $display("[TB] FAIL select_gesture: got sel=%0d expected 2", sel);
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (edit_val !== 16'd60) begin
            errors++;
            $display("[TB] FAIL load_shadow: got %0d expected 60", edit_val);
        end
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (edit_val !== 16'd75) begin
            errors++;
            $display("[TB] FAIL inc_by_5: got %0d expected 75", edit_val);
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checks++;
        if ({preset2, cfg_done} !== {16'd60, 1'b0}) begin
            errors++;
            $display("[TB] FAIL commit_edge1: got preset2=%0d done=%0b expected 60/0", preset2, cfg_done);
        end
        @(negedge clk);
        checks++;
        if ({preset2, cfg_done, cfg_busy} !== {16'd75, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL commit_edge2: got preset2=%0d done=%0b busy=%0b expected 75/1/1",
                     preset2, cfg_done, cfg_busy);
        end
        checks++;
        if ({preset0, preset1, preset3} !== {16'd3600, 16'd180, 16'd5}) begin
            errors++;
            $display("[TB] FAIL commit_others: got %0d/%0d/%0d expected 3600/180/5", preset0, preset1, preset3);
        end
        @(negedge clk);
        checks++;
        if (cfg_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_one_cycle: got done=%0b expected 0", cfg_done);
        end
    endtask

    task automatic test_saturation();
        // sel is 2 in SELECT; wrap to slot 0
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checks++;
        if ({sel, edit_val} !== {2'd0, 16'd3600}) begin
            errors++;
            $display("[TB] FAIL load_slot0: got sel=%0d edit=%0d expected 0/3600", sel, edit_val);
        end
        step = 4'd15;
        for (int i = 0; i < 160; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (edit_val !== 16'd5999) begin
            errors++;
            $display("[TB] FAIL climb_to_max: got %0d expected 5999", edit_val);
        end
        step = 4'd9;
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (edit_val !== 16'd5999) begin
            errors++;
            $display("[TB] FAIL clamp_max: got %0d expected 5999", edit_val);
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        checks++;
        if (preset0 !== 16'd5999) begin
            errors++;
            $display("[TB] FAIL commit_max: got %0d expected 5999", preset0);
        end
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checks++;
        if ({sel, edit_val} !== {2'd3, 16'd5}) begin
            errors++;
            $display("[TB] FAIL load_slot3: got sel=%0d edit=%0d expected 3/5", sel, edit_val);
        end
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (edit_val !== 16'd1) begin
            errors++;
            $display("[TB] FAIL clamp_min: got %0d expected 1", edit_val);
        end
        step = 4'd0;
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (edit_val !== 16'd1) begin
            errors++;
            $display("[TB] FAIL dec_at_min: got %0d expected 1", edit_val);
        end
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (edit_val !== 16'd2) begin
            errors++;
            $display("[TB] FAIL step_zero_as_one: got %0d expected 2", edit_val);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if ({preset3, edit_val, cfg_busy} !== {16'd5, 16'd2, 1'b1}) begin
            errors++;
            $display("[TB] FAIL edit_cancel_slot3: got preset3=%0d edit=%0d busy=%0b expected 5/2/1",
                     preset3, edit_val, cfg_busy);
        end
    endtask

    task automatic test_cancel();
        // sel is 3 in SELECT; wrap to slot 1
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        step = 4'd1;
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checks++;
        if ({sel, edit_val} !== {2'd1, 16'd184}) begin
            errors++;
            $display("[TB] FAIL inc_slot1: got sel=%0d edit=%0d expected 1/184", sel, edit_val);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checks++;
        if ({preset1, edit_val, cfg_done, cfg_busy} !== {16'd180, 16'd184, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL cancel_edit: got preset1=%0d edit=%0d done=%0b busy=%0b expected 180/184/0/1",
                     preset1, edit_val, cfg_done, cfg_busy);
        end
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (sel !== 2'd1) begin
            errors++;
            $display("[TB] FAIL sel_wrap: got sel=%0d expected 1", sel);
        end
    endtask

    task automatic test_priority();
        // set_req outside IDLE must not reset sel
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (sel !== 2'd1) begin
            errors++;
            $display("[TB] FAIL set_req_ignored: got sel=%0d expected 1", sel);
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        @(negedge clk);
        checks++;
        if ({preset1, cfg_done} !== {16'd180, 1'b0}) begin
            errors++;
            $display("[TB] FAIL cancel_beats_confirm: got preset1=%0d done=%0b expected 180/0",
                     preset1, cfg_done);
        end
        // Back in SELECT: confirm reloads; then inc+confirm commits unchanged
        step = 4'd7;
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 1, 0, 0);
        checks++;
        if (edit_val !== 16'd180) begin
            errors++;
            $display("[TB] FAIL confirm_beats_inc: got edit=%0d expected 180", edit_val);
        end
        @(negedge clk);
        checks++;
        if ({preset1, cfg_done} !== {16'd180, 1'b1}) begin
            errors++;
            $display("[TB] FAIL priority_commit: got preset1=%0d done=%0b expected 180/1", preset1, cfg_done);
        end
        // inc beats dec inside EDIT
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        checks++;
        if (edit_val !== 16'd187) begin
            errors++;
            $display("[TB] FAIL inc_beats_dec: got edit=%0d expected 187", edit_val);
        end
    endtask

    task automatic test_reset_mid_edit();
        // Still in EDIT on slot 1 with edit_val = 187; preset0 holds 5999
        reset = 1'b0;
        #1;
        checks++;
        if ({cfg_busy, edit_val, sel, preset0, preset2} !== {1'b0, 16'd0, 2'd0, 16'd3600, 16'd60}) begin
            errors++;
            $display("[TB] FAIL reset_mid_edit: got busy=%0b edit=%0d sel=%0d p0=%0d p2=%0d expected 0/0/0/3600/60",
                     cfg_busy, edit_val, sel, preset0, preset2);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(0, 0, 1, 0, 1, 0, 0);
        checks++;
        if ({cfg_busy, edit_val} !== {1'b0, 16'd0}) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got busy=%0b edit=%0d expected 0/0", cfg_busy, edit_val);
        end
    endtask

`ifdef PRESET_RESTORE_EN
    task automatic test_restore();
        step = 4'd10;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (preset1 !== 16'd200) begin
            errors++;
            $display("[TB] FAIL restore_setup: got preset1=%0d expected 200", preset1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({preset1, cfg_done, cfg_busy} !== {16'd180, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL restore_select: got preset1=%0d done=%0b busy=%0b expected 180/1/1",
                     preset1, cfg_done, cfg_busy);
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({preset1, cfg_done, edit_val} !== {16'd200, 1'b0, 16'd200}) begin
            errors++;
            $display("[TB] FAIL restore_in_edit: got preset1=%0d done=%0b edit=%0d expected 200/0/200",
                     preset1, cfg_done, edit_val);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checks++;
        if ({preset1, cfg_busy} !== {16'd200, 1'b0}) begin
            errors++;
            $display("[TB] FAIL cancel_beats_restore: got preset1=%0d busy=%0b expected 200/0",
                     preset1, cfg_busy);
        end
    endtask
`endif

    initial begin
        errors      = 0;
        checks      = 0;
        reset       = 1'b0;
        set_req     = 1'b0;
        sel_next    = 1'b0;
        step        = 4'd1;
        inc         = 1'b0;
        dec         = 1'b0;
        confirm     = 1'b0;
        cancel      = 1'b0;
        restore_def = 1'b0;
        @(negedge clk);
        test_reset();
        test_commit();
        test_saturation();
        test_cancel();
        test_priority();
        test_reset_mid_edit();
`ifdef PRESET_RESTORE_EN
        test_restore();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
